// File: rtl/round_referee_if.sv
// Round interface: button pads and game state in, arbitration result out.
interface round_referee_if;
    logic pbl;
    logic pbr;
    logic game_over;
    logic winrnd;
    logic right;
    logic tie;
    logic leds_on;

    modport master (
        input  pbl,
        input  pbr,
        input  game_over,
        output winrnd,
        output right,
        output tie,
        output leds_on
    );

    modport slave (
        output pbl,
        output pbr,
        output game_over,
        input  winrnd,
        input  right,
        input  tie,
        input  leds_on
    );
endinterface

// File: rtl/round_referee.sv
// Tug-of-war round controller: random dark wait, go-LED, first-push arbitration.
module round_referee #(
    parameter logic [15:0] MIN_WAIT   = 16'd64,
    parameter int unsigned RAND_SHIFT = 2,
    parameter logic [15:0] ON_TIMEOUT = 16'd1000
) (
    input  logic            clk,
    input  logic            rst,
    round_referee_if.master bus
);

    typedef enum logic [2:0] {
        S_RELEASE,
        S_DARK,
        S_LIT,
        S_REPORT,
        S_HOLD
    } state_t;

    state_t      state;
    state_t      state_n;

    logic [1:0]  l_sync;
    logic [1:0]  r_sync;
    logic        l_dly;
    logic        r_dly;
    logic        l_high;
    logic        r_high;
    logic        ev_l;
    logic        ev_r;
    logic        ev_any;
    logic        arb_right;
    logic        arb_tie;

    logic [7:0]  lfsr;
    logic        lfsr_fb;
    logic [15:0] rand_ext;
    logic [16:0] load_sum;
    logic [15:0] load_val;

    logic [15:0] cnt;
    logic [15:0] cnt_n;

    logic        winrnd_q;
    logic        right_q;
    logic        tie_q;
    logic        leds_q;
    logic        winrnd_n;
    logic        right_n;
    logic        tie_n;
    logic        leds_n;

    // Two flops against metastability, one more to find the rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l_sync <= 2'b00;
            r_sync <= 2'b00;
            l_dly  <= 1'b0;
            r_dly  <= 1'b0;
        end else begin
            l_sync <= {l_sync[0], bus.pbl};
            r_sync <= {r_sync[0], bus.pbr};
            l_dly  <= l_sync[1];
            r_dly  <= r_sync[1];
        end
    end

    assign l_high    = l_sync[1];
    assign r_high    = r_sync[1];
    assign ev_l      = l_high & ~l_dly;
    assign ev_r      = r_high & ~r_dly;
    assign ev_any    = ev_l | ev_r;
    assign arb_right = ev_r & ~ev_l;
    assign arb_tie   = ev_r & ev_l;

    assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr_fb};
        end
    end

    // Dark interval load, clamped rather than wrapping to a short wait.
    assign rand_ext = {8'b0, lfsr} << RAND_SHIFT;
    assign load_sum = {1'b0, MIN_WAIT} + {1'b0, rand_ext};
    assign load_val = load_sum[16] ? 16'hFFFF : load_sum[15:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_RELEASE;
            cnt   <= 16'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        winrnd_n = 1'b0;
        right_n  = right_q;
        tie_n    = tie_q;
        leds_n   = leds_q;
        unique case (state)
            S_RELEASE: begin
                leds_n = 1'b0;
                if (bus.game_over) begin
                    state_n = S_HOLD;
                end else if (!l_high && !r_high) begin
                    state_n = S_DARK;
                    cnt_n   = load_val;
                end
            end
            S_DARK: begin
                leds_n = 1'b0;
                if (bus.game_over) begin
                    state_n = S_HOLD;
                end else if (ev_any) begin
                    state_n  = S_REPORT;
                    winrnd_n = 1'b1;
                    right_n  = arb_right;
                    tie_n    = arb_tie;
                end else if (cnt == 16'd0) begin
                    state_n = S_LIT;
                    cnt_n   = ON_TIMEOUT;
                    leds_n  = 1'b1;
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            S_LIT: begin
                leds_n = 1'b1;
                if (bus.game_over) begin
                    state_n = S_HOLD;
                    leds_n  = 1'b0;
                end else if (ev_any) begin
                    state_n  = S_REPORT;
                    winrnd_n = 1'b1;
                    right_n  = arb_right;
                    tie_n    = arb_tie;
                end else if (cnt == 16'd0) begin
                    state_n = S_RELEASE;
                    leds_n  = 1'b0;
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            S_REPORT: begin
                leds_n  = 1'b0;
                state_n = bus.game_over ? S_HOLD : S_RELEASE;
            end
            S_HOLD: begin
                leds_n = 1'b0;
                if (!bus.game_over) begin
                    state_n = S_RELEASE;
                end
            end
            default: begin
                state_n = S_RELEASE;
                leds_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            winrnd_q <= 1'b0;
            right_q  <= 1'b0;
            tie_q    <= 1'b0;
            leds_q   <= 1'b0;
        end else begin
            winrnd_q <= winrnd_n;
            right_q  <= right_n;
            tie_q    <= tie_n;
            leds_q   <= leds_n;
        end
    end

    assign bus.winrnd  = winrnd_q;
    assign bus.right   = right_q;
    assign bus.tie     = tie_q;
    assign bus.leds_on = leds_q;

endmodule

// File: tb/tb_round_referee.sv
// Bench for round_referee: randomized rounds against a timing model
// derived from the LFSR sequence and the round rules.
module tb_round_referee;
    localparam logic [15:0] MIN_WAIT   = 16'd4;
    localparam int          RAND_SHIFT = 2;
    localparam logic [15:0] ON_TIMEOUT = 16'd8;
    localparam int          BOUND      = 3000;

    logic clk = 1'b0;
    logic rst = 1'b0;

    round_referee_if bus ();

    round_referee #(
        .MIN_WAIT  (MIN_WAIT),
        .RAND_SHIFT(RAND_SHIFT),
        .ON_TIMEOUT(ON_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc;
    int pulses = 0;

    // Clock edges seen since reset was released.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (bus.winrnd === 1'b1) pulses <= pulses + 1;
    end

    function automatic logic [7:0] lfsr_after(input int n);
        logic [7:0] v;
        v = 8'hA5;
        for (int i = 0; i < n; i++)
            v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
        return v;
    endfunction

    // Dark load value when DARK is entered on the edge after n edges.
    function automatic int load_of(input int n);
        int s;
        s = int'(MIN_WAIT) + (int'(lfsr_after(n)) << RAND_SHIFT);
        return (s > 65535) ? 65535 : s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.pbl = 1'b0;
        bus.pbr = 1'b0;
        bus.game_over = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_rise(output int r);
        bit armed;
        armed = !bus.leds_on;
        r = -1;
        for (int i = 0; i < BOUND; i++) begin
            tick();
            if (!bus.leds_on) armed = 1'b1;
            else if (armed) begin
                r = cyc;
                break;
            end
        end
        if (r < 0) begin
            checks++;
            errors++;
            $display("FAIL wait_rise: leds_on no rise in %0d cycles", BOUND);
        end
    endtask

    task automatic test_reset();
        bus.pbl = 1'b0;
        bus.pbr = 1'b0;
        bus.game_over = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.winrnd, bus.right, bus.tie, bus.leds_on} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: got w%b r%b t%b l%b, need 0000",
                     bus.winrnd, bus.right, bus.tie, bus.leds_on);
        end
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_timeout();
        int r1, r2, n, f, p0;
        do_reset();
        p0 = pulses;
        wait_rise(r1);
        checks++;
        if (r1 !== load_of(0) + 2) begin
            errors++;
            $display("FAIL first_dark: rise at %0d, need %0d", r1, load_of(0) + 2);
        end
        n = 1;
        for (int i = 0; i < BOUND; i++) begin
            tick();
            if (bus.leds_on) n++;
            else break;
        end
        f = cyc;
        checks++;
        if (n !== int'(ON_TIMEOUT) + 1) begin
            errors++;
            $display("FAIL lit_length: %0d cycles, need %0d", n, int'(ON_TIMEOUT) + 1);
        end
        checks++;
        if (pulses !== p0) begin
            errors++;
            $display("FAIL timeout_pulse: %0d pulses, need 0", pulses - p0);
        end
        wait_rise(r2);
        checks++;
        if (r2 !== f + 2 + load_of(f)) begin
            errors++;
            $display("FAIL second_dark: rise at %0d, need %0d", r2, f + 2 + load_of(f));
        end
    endtask

    task automatic test_legal();
        int r, d, p0;
        bit who;
        for (int k = 0; k < 4; k++) begin
            wait_rise(r);
            d = $urandom_range(0, 6);
            who = 1'($urandom_range(0, 1));
            repeat (d) tick();
            p0 = pulses;
            if (who) bus.pbr = 1'b1;
            else     bus.pbl = 1'b1;
            tick();
            tick();
            checks++;
            if (bus.winrnd !== 1'b0) begin
                errors++;
                $display("FAIL legal_early: winrnd %b two edges after push, need 0", bus.winrnd);
            end
            tick();
            checks++;
            if ({bus.winrnd, bus.right, bus.tie, bus.leds_on} !== {1'b1, who, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL legal_win: got w%b r%b t%b l%b, need w1 r%b t0 l1",
                         bus.winrnd, bus.right, bus.tie, bus.leds_on, who);
            end
            tick();
            checks++;
            if ({bus.winrnd, bus.leds_on} !== 2'b00) begin
                errors++;
                $display("FAIL legal_after: got w%b l%b, need 00", bus.winrnd, bus.leds_on);
            end
            tick();
            bus.pbl = 1'b0;
            bus.pbr = 1'b0;
            repeat (3) tick();
            checks++;
            if (pulses !== p0 + 1) begin
                errors++;
                $display("FAIL legal_count: %0d pulses, need 1", pulses - p0);
            end
        end
    endtask

    task automatic test_tie();
        int r, d, p0, q, r2;
        bit lit;
        wait_rise(r);
        d = $urandom_range(0, 6);
        repeat (d) tick();
        bus.pbl = 1'b1;
        bus.pbr = 1'b1;
        repeat (3) tick();
        checks++;
        if ({bus.winrnd, bus.right, bus.tie, bus.leds_on} !== 4'b1011) begin
            errors++;
            $display("FAIL tie_win: got w%b r%b t%b l%b, need w1 r0 t1 l1",
                     bus.winrnd, bus.right, bus.tie, bus.leds_on);
        end
        repeat (2) tick();
        bus.pbl = 1'b0;
        repeat (3) tick();
        bus.pbl = 1'b1;
        p0 = pulses;
        lit = 1'b0;
        repeat (1100) begin
            tick();
            if (bus.leds_on) lit = 1'b1;
        end
        checks++;
        if (pulses !== p0 || lit) begin
            errors++;
            $display("FAIL tie_held: %0d pulses lit=%b, need 0 pulses lit=0",
                     pulses - p0, lit);
        end
        bus.pbl = 1'b0;
        bus.pbr = 1'b0;
        q = cyc;
        wait_rise(r2);
        checks++;
        if (r2 !== q + 4 + load_of(q + 2)) begin
            errors++;
            $display("FAIL release_dark: rise at %0d, need %0d", r2, q + 4 + load_of(q + 2));
        end
    endtask

    task automatic test_game_over();
        int r, h, p0, r2;
        bit lit;
        wait_rise(r);
        repeat ($urandom_range(0, 3)) tick();
        bus.game_over = 1'b1;
        tick();
        checks++;
        if (bus.leds_on !== 1'b0) begin
            errors++;
            $display("FAIL hold_led: leds_on %b, need 0", bus.leds_on);
        end
        p0 = pulses;
        lit = 1'b0;
        bus.pbr = 1'b1;
        repeat (5) begin
            tick();
            if (bus.leds_on) lit = 1'b1;
        end
        bus.pbr = 1'b0;
        bus.pbl = 1'b1;
        repeat (6) begin
            tick();
            if (bus.leds_on) lit = 1'b1;
        end
        bus.pbl = 1'b0;
        repeat (5) begin
            tick();
            if (bus.leds_on) lit = 1'b1;
        end
        checks++;
        if (pulses !== p0 || lit) begin
            errors++;
            $display("FAIL hold_quiet: %0d pulses lit=%b, need 0 pulses lit=0",
                     pulses - p0, lit);
        end
        bus.game_over = 1'b0;
        h = cyc;
        wait_rise(r2);
        checks++;
        if (r2 !== h + 3 + load_of(h + 1)) begin
            errors++;
            $display("FAIL hold_exit: rise at %0d, need %0d", r2, h + 3 + load_of(h + 1));
        end
    endtask

    task automatic test_reset_mid_dark();
        int r, p0, r2;
        wait_rise(r);
        bus.pbr = 1'b1;
        repeat (3) tick();
        checks++;
        if ({bus.winrnd, bus.right} !== 2'b11) begin
            errors++;
            $display("FAIL pre_reset_win: got w%b r%b, need w1 r1", bus.winrnd, bus.right);
        end
        tick();
        bus.pbr = 1'b0;
        repeat (6) tick();
        p0 = pulses;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.winrnd, bus.right, bus.tie, bus.leds_on} !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset: got w%b r%b t%b l%b, need 0000",
                     bus.winrnd, bus.right, bus.tie, bus.leds_on);
        end
        tick();
        tick();
        rst = 1'b0;
        wait_rise(r2);
        checks++;
        if (r2 !== load_of(0) + 2 || pulses !== p0) begin
            errors++;
            $display("FAIL reset_lfsr: rise %0d pulses %0d, need rise %0d pulses 0",
                     r2, pulses - p0, load_of(0) + 2);
        end
    endtask

    task automatic test_jump();
        int k;
        bit lit;
        for (int n = 0; n < 2; n++) begin
            do_reset();
            k = $urandom_range(2, 600);
            lit = 1'b0;
            while (cyc < k) begin
                tick();
                if (bus.leds_on) lit = 1'b1;
            end
            bus.pbl = 1'b1;
            repeat (3) begin
                tick();
                if (bus.leds_on) lit = 1'b1;
            end
            checks++;
            if ({bus.winrnd, bus.right, bus.tie, bus.leds_on, lit} !== 5'b10000) begin
                errors++;
                $display("FAIL jump_left: got w%b r%b t%b l%b lit=%b, need w1 r0 t0 l0 lit=0",
                         bus.winrnd, bus.right, bus.tie, bus.leds_on, lit);
            end
            tick();
            bus.pbl = 1'b0;
            repeat (3) tick();
        end
    endtask

    task automatic test_boundary();
        int l;
        do_reset();
        l = load_of(0);
        while (cyc < l - 1) tick();
        bus.pbl = 1'b1;
        repeat (3) tick();
        checks++;
        if ({bus.winrnd, bus.right, bus.tie, bus.leds_on} !== 4'b1000) begin
            errors++;
            $display("FAIL expiry_push: got w%b r%b t%b l%b at %0d, need w1 r0 t0 l0",
                     bus.winrnd, bus.right, bus.tie, bus.leds_on, cyc);
        end
        tick();
        checks++;
        if (bus.leds_on !== 1'b0) begin
            errors++;
            $display("FAIL expiry_after: leds_on %b, need 0", bus.leds_on);
        end
        bus.pbl = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_legal();
        test_tie();
        test_game_over();
        test_reset_mid_dark();
        test_jump();
        test_boundary();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
